oram_posmap: RTL and testbench
==============================

ORAM_POSMAP -- requirements
Module: oram_posmap

Interface
REQ-001 Parameter D, default 6, meaning tree depth and block-number width; legal range 2..9.
REQ-002 Parameter LFSR_SEED, default 16'hACE1, meaning LFSR reset value; a value of 0 SHALL be replaced by 16'hACE1.
REQ-003 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 req_valid  input  1  lookup/remap request present.
REQ-006 req_ready  output  1  block accepts a request this cycle.
REQ-007 req_block  input  D  block number to look up.
REQ-008 rsp_valid  output  1  response present.
REQ-009 rsp_ready  input  1  downstream path-fetch stage accepts the response.
REQ-010 rsp_old_leaf  output  D-1  leaf the block currently maps to; the fetch stage reads this path.
REQ-011 rsp_new_leaf  output  D-1  freshly drawn leaf for put-back.
REQ-012 rsp_was_empty  output  1  block had no valid mapping before this request.
REQ-013 stat_req_count  output  16  accepted-request counter.
REQ-014 stat_miss_count  output  16  empty-mapping counter.

Function
REQ-015 Table: 2^D entries of {leaf[D-2:0], valid}.
REQ-016 LFSR: 16-bit Galois, mask 16'hB400, shift right; advances every cycle outside reset.
REQ-017 FSM states: INIT, IDLE, RESP.
REQ-018 INIT: clear valid of entry idx, idx = 0..2^D-1, one entry per cycle; req_ready=0; on idx=2^D-1, go to IDLE.
REQ-019 IDLE: req_ready=1; on req_valid=1, capture the response, write the table, go to RESP.
REQ-020 Capture at acceptance: rsp_was_empty = !valid[req_block].
REQ-021 rsp_old_leaf = leaf[req_block] if valid, else lfsr[D-2:0].
REQ-022 rsp_new_leaf = lfsr[2D-3:D-1].
REQ-023 Table write on the same edge: leaf[req_block] = rsp_new_leaf; valid = 1.
REQ-024 Latency: rsp_valid is 1 on the cycle after acceptance.
REQ-025 RESP: rsp_valid=1 and req_ready=0; all rsp_* outputs held stable until rsp_valid && rsp_ready; then go to IDLE.
REQ-026 Throughput: at most one request per 2 cycles; a request is never accepted in the same cycle as a response handshake.
REQ-027 rsp_ready may be asserted before rsp_valid; it has no effect outside RESP.
REQ-028 req_block is sampled only at acceptance; changes at any other time have no effect.

Reset
REQ-029 rst_n=0 at any edge: state=INIT, idx=0, lfsr=LFSR_SEED.
REQ-030 rst_n=0 at any edge: rsp_valid=0, req_ready=0, rsp_old_leaf=0, rsp_new_leaf=0, rsp_was_empty=0.
REQ-031 rst_n=0 at any edge: stat counters=0.
REQ-032 Reset during RESP or INIT: the pending response is discarded and the full INIT sweep restarts.
REQ-033 Table leaf contents are don't-care after reset; only valid bits are cleared, by the sweep.

Configuration
REQ-034 Macro ORAM_POSMAP_STATS_EN defined: stat_req_count increments on each accepted request.
REQ-035 Macro ORAM_POSMAP_STATS_EN defined: stat_miss_count increments on each accepted request with rsp_was_empty=1.
REQ-036 Macro ORAM_POSMAP_STATS_EN defined: both counters saturate at 16'hFFFF.
REQ-037 Macro ORAM_POSMAP_STATS_EN not defined: both stat ports remain present and are constant 0, with no counter logic.

Verification
REQ-038 Release reset with D=6 -> req_ready=0 for exactly 64 cycles, then 1 on cycle 65.
REQ-039 First request for block 5 -> rsp_valid 1 cycle later, rsp_was_empty=1, old/new leaves match the reference LFSR model.
REQ-040 Second request for block 5 -> rsp_was_empty=0 and rsp_old_leaf equals the previous rsp_new_leaf.
REQ-041 rsp_ready held 0 for 10 cycles in RESP -> rsp_* stable, req_ready=0; rsp_ready=1 -> rsp_valid=0 and req_ready=1 on the next cycle.
REQ-042 rst_n=0 for 1 cycle while in RESP -> rsp_valid=0 next cycle, 64-cycle INIT repeats, and block 5 then reports rsp_was_empty=1.
REQ-043 With ORAM_POSMAP_STATS_EN, requests for blocks 3, 3, 7 -> stat_req_count=3, stat_miss_count=2; without the macro -> both 0.

Source files
------------

// File: rtl/oram_posmap.sv
// ORAM position map: block -> leaf table with LFSR-drawn remapping and a one-deep response stage.
// Optional statistics counters are enabled by defining ORAM_POSMAP_STATS_EN.
module oram_posmap #(
    parameter int          D         = 6,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [D-1:0] req_block,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [D-2:0] rsp_old_leaf,
    output logic [D-2:0] rsp_new_leaf,
    output logic         rsp_was_empty,
    output logic [15:0]  stat_req_count,
    output logic [15:0]  stat_miss_count
);

    localparam int          N         = 1 << D;
    localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [D-1:0] LAST_IDX = {D{1'b1}};

    typedef enum logic [1:0] {INIT, IDLE, RESP} state_t;

    state_t       state;
    logic [D-1:0] idx;
    logic [15:0]  lfsr;
    logic [N-1:0] tbl_vld;
    logic [D-2:0] tbl_leaf [N];

    logic         accept;
    logic         hit_vld;
    logic [D-2:0] old_leaf;
    logic [D-2:0] new_leaf;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        lfsr_next = (cur >> 1) ^ (cur[0] ? LFSR_MASK : 16'h0000);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] cur);
        sat_inc = (cur == 16'hFFFF) ? cur : cur + 16'd1;
    endfunction

    assign accept   = rst_n && (state == IDLE) && req_valid;
    assign hit_vld  = tbl_vld[req_block];
    assign new_leaf = lfsr[2*D-3:D-1];
    // An unmapped block reads a random path so its first access looks like any other.
    assign old_leaf = hit_vld ? tbl_leaf[req_block] : lfsr[D-2:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= INIT;
            idx           <= '0;
            req_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_old_leaf  <= '0;
            rsp_new_leaf  <= '0;
            rsp_was_empty <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    if (req_valid) begin
                        rsp_old_leaf  <= old_leaf;
                        rsp_new_leaf  <= new_leaf;
                        rsp_was_empty <= !hit_vld;
                        state         <= RESP;
                        req_ready     <= 1'b0;
                        rsp_valid     <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= INIT;
                    idx       <= '0;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Leaf contents are never reset; only the valid bits are cleared, by the INIT sweep.
    always_ff @(posedge clk) begin
        if (rst_n && (state == INIT)) begin
            tbl_vld[idx] <= 1'b0;
        end else if (accept) begin
            tbl_vld[req_block]  <= 1'b1;
            tbl_leaf[req_block] <= new_leaf;
        end
    end

`ifdef ORAM_POSMAP_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_req_count  <= '0;
            stat_miss_count <= '0;
        end else if (accept) begin
            stat_req_count <= sat_inc(stat_req_count);
            if (!hit_vld) begin
                stat_miss_count <= sat_inc(stat_miss_count);
            end
        end
    end
`else
    assign stat_req_count  = '0;
    assign stat_miss_count = '0;
`endif

endmodule

// File: tb/tb_oram_posmap.sv
// Directed bench for oram_posmap with a transaction-level reference model checked every cycle.
module tb_oram_posmap;

    localparam int D     = 6;
    localparam int N     = 1 << D;
    localparam int LEAFS = 1 << (D - 1);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [D-1:0] req_block = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [D-2:0] rsp_old_leaf;
    logic [D-2:0] rsp_new_leaf;
    logic         rsp_was_empty;
    logic [15:0]  stat_req_count;
    logic [15:0]  stat_miss_count;

    int checks = 0;
    int failures = 0;

    oram_posmap #(.D(D), .LFSR_SEED(16'hACE1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_block      (req_block),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_old_leaf   (rsp_old_leaf),
        .rsp_new_leaf   (rsp_new_leaf),
        .rsp_was_empty  (rsp_was_empty),
        .stat_req_count (stat_req_count),
        .stat_miss_count(stat_miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference model: mapping table, outstanding-response flag, init countdown.
    bit          m_started = 0;
    int          m_init_left = 0;
    bit          m_pend = 0;
    bit          m_vld [N];
    int          m_leaf [N];
    int          m_old = 0;
    int          m_new = 0;
    bit          m_empty = 0;
    logic [15:0] m_lfsr = 16'hACE1;
    int          m_req = 0;
    int          m_miss = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_started   = 1;
            m_init_left = N;
            m_pend      = 0;
            m_old       = 0;
            m_new       = 0;
            m_empty     = 0;
            m_lfsr      = 16'hACE1;
            m_req       = 0;
            m_miss      = 0;
            foreach (m_vld[i]) m_vld[i] = 0;
        end else begin
            if (m_init_left > 0) begin
                m_init_left--;
            end else if (!m_pend && req_valid) begin
                int b;
                b       = int'(req_block);
                m_empty = !m_vld[b];
                m_old   = m_vld[b] ? m_leaf[b] : (int'(m_lfsr) % LEAFS);
                m_new   = (int'(m_lfsr) >> (D - 1)) % LEAFS;
                m_leaf[b] = m_new;
                m_vld[b]  = 1;
                m_pend    = 1;
                if (m_req < 16'hFFFF) m_req++;
                if (m_empty && m_miss < 16'hFFFF) m_miss++;
            end else if (m_pend && rsp_ready) begin
                m_pend = 0;
            end
            m_lfsr = lfsr_step(m_lfsr);
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("req_ready", req_ready, (m_init_left == 0 && !m_pend) ? 1 : 0);
            check("rsp_valid", rsp_valid, m_pend ? 1 : 0);
            if (m_pend) begin
                check("rsp_old_leaf", rsp_old_leaf, m_old);
                check("rsp_new_leaf", rsp_new_leaf, m_new);
                check("rsp_was_empty", rsp_was_empty, m_empty);
            end
`ifdef ORAM_POSMAP_STATS_EN
            check("stat_req_count", stat_req_count, m_req);
            check("stat_miss_count", stat_miss_count, m_miss);
`else
            check("stat_req_count", stat_req_count, 0);
            check("stat_miss_count", stat_miss_count, 0);
`endif
        end
    end

    logic [D-2:0] cap_old;
    logic [D-2:0] cap_new;
    logic         cap_empty;

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) check("ready_timeout", req_ready, 1);
    endtask

    task automatic do_req(input int blk);
        wait_ready();
        req_valid = 1'b1;
        req_block = D'(blk);
        @(negedge clk);
        req_valid = 1'b0;
        req_block = ~req_block;
        check("rsp_latency", rsp_valid, 1);
        cap_old   = rsp_old_leaf;
        cap_new   = rsp_new_leaf;
        cap_empty = rsp_was_empty;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_drop", rsp_valid, 0);
    endtask

    task automatic reset_and_count(input int cyc);
        int n = 0;
        rst_n = 1'b0;
        repeat (cyc) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_old_leaf", rsp_old_leaf, 0);
        check("rst_new_leaf", rsp_new_leaf, 0);
        check("rst_was_empty", rsp_was_empty, 0);
        check("rst_stat_req", stat_req_count, 0);
        check("rst_stat_miss", stat_miss_count, 0);
        rst_n = 1'b1;
        while (req_ready !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("init_cycles", n, 64);
    endtask

    initial begin
        logic [15:0]  v;
        logic [D-2:0] n5;

        check("lfsr_step1", lfsr_step(16'hACE1), 16'hE270);
        v = 16'hACE1;
        repeat (6) v = lfsr_step(v);
        check("lfsr_step6", v, 16'hB313);

        reset_and_count(2);

        do_req(5);
        check("first_empty", cap_empty, 1);
        n5 = cap_new;

        // A stray request for block 9 waits while the response is stalled.
        req_valid = 1'b1;
        req_block = 6'd9;
        repeat (10) begin
            @(negedge clk);
            check("hold_old", rsp_old_leaf, cap_old);
            check("hold_new", rsp_new_leaf, cap_new);
            check("hold_empty", rsp_was_empty, cap_empty);
            check("hold_valid", rsp_valid, 1);
            check("hold_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("hs_valid", rsp_valid, 0);
        check("hs_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        check("blk9_valid", rsp_valid, 1);
        check("blk9_empty", rsp_was_empty, 1);
        @(negedge clk);
        check("blk9_drop", rsp_valid, 0);
        rsp_ready = 1'b0;

        do_req(5);
        check("second_empty", cap_empty, 0);
        check("old_eq_prev_new", cap_old, n5);
        finish_rsp();

        do_req(0);
        finish_rsp();
        do_req(63);
        check("blk63_first_empty", cap_empty, 1);
        finish_rsp();
        do_req(63);
        check("blk63_second_empty", cap_empty, 0);
        finish_rsp();

        do_req(5);
        reset_and_count(1);

        do_req(3);
        finish_rsp();
        do_req(3);
        finish_rsp();
        do_req(7);
        finish_rsp();
`ifdef ORAM_POSMAP_STATS_EN
        check("stats_req_lit", stat_req_count, 3);
        check("stats_miss_lit", stat_miss_count, 2);
`else
        check("stats_req_lit", stat_req_count, 0);
        check("stats_miss_lit", stat_miss_count, 0);
`endif

        do_req(5);
        check("post_reset_empty", cap_empty, 1);
        finish_rsp();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
